// File: rtl/cache_fill_ctrl_param.sv
// Cache-miss block fill controller: issues pipelined word reads through an arbitrated
// memory port, writes returned words into the data array and the tag on the last word.
module cache_fill_ctrl_param #(
  parameter int ADDR_W          = 16,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CRITICAL_FIRST  = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               miss_detected,
  input  logic [ADDR_W-1:0]                  miss_address,
  input  logic                               mem_grant,
  input  logic                               mem_data_valid,
  output logic                               mem_req,
  output logic [ADDR_W-1:0]                  memory_address,
  output logic                               fsm_busy,
  output logic                               write_data_array,
  output logic                               write_tag_array,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] word_num,
  output logic                               crit_word_valid,
  output logic                               error
);

  localparam int LW = $clog2(WORDS_PER_BLOCK);
  localparam int CW = LW + 1;
  localparam logic [CW-1:0] W_C    = CW'(WORDS_PER_BLOCK);
  localparam logic [CW-1:0] LAST_C = CW'(WORDS_PER_BLOCK - 1);
  localparam logic [CW-1:0] MAX_C  = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] ZERO_C = CW'(0);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t              state_r;
  logic [ADDR_W-1:0]   base_r;
  logic [LW-1:0]       start_r;
  logic [LW-1:0]       miss_word_r;
  logic [CW-1:0]       issue_cnt_r;
  logic [CW-1:0]       recv_cnt_r;
  logic                error_r;

  logic [LW-1:0]       miss_word_in_s;
  logic [LW-1:0]       start_in_s;
  logic [ADDR_W-1:0]   base_in_s;
  logic [CW-1:0]       outstanding_s;
  logic [LW-1:0]       issue_idx_s;
  logic [LW-1:0]       recv_idx_s;
  logic                issue_s;
  logic                recv_s;
  logic                last_s;
  logic                bad_data_s;

  assign miss_word_in_s = miss_address[LW:1];
  assign start_in_s     = (CRITICAL_FIRST != 0) ? miss_word_in_s : {LW{1'b0}};
  assign base_in_s      = {miss_address[ADDR_W-1:LW+1], {(LW+1){1'b0}}};
  // Counters are one bit wider than the word index, so the index sums wrap modulo the block.
  assign outstanding_s  = issue_cnt_r - recv_cnt_r;
  assign issue_idx_s    = start_r + issue_cnt_r[LW-1:0];
  assign recv_idx_s     = start_r + recv_cnt_r[LW-1:0];
  assign error          = error_r;

  // Output decode and issue/receive qualification for the current state.
  always_comb begin
    mem_req          = 1'b0;
    memory_address   = {ADDR_W{1'b0}};
    fsm_busy         = 1'b0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    word_num         = {LW{1'b0}};
    crit_word_valid  = 1'b0;
    issue_s          = 1'b0;
    recv_s           = 1'b0;
    last_s           = 1'b0;
    bad_data_s       = 1'b0;
    case (state_r)
      IDLE: begin
        fsm_busy       = miss_detected;
        memory_address = miss_address;
        bad_data_s     = mem_data_valid;
      end
      FILL: begin
        fsm_busy       = 1'b1;
        mem_req        = (issue_cnt_r < W_C) && (outstanding_s < MAX_C);
        memory_address = base_r | {{(ADDR_W-LW-1){1'b0}}, issue_idx_s, 1'b0};
        issue_s        = mem_req && mem_grant;
        if (mem_data_valid) begin
          if (outstanding_s != ZERO_C) begin
            recv_s = 1'b1;
          end else begin
            bad_data_s = 1'b1;
          end
        end else begin
          recv_s     = 1'b0;
          bad_data_s = 1'b0;
        end
        if (recv_s) begin
          write_data_array = 1'b1;
          word_num         = recv_idx_s;
          crit_word_valid  = (recv_idx_s == miss_word_r);
          last_s           = (recv_cnt_r == LAST_C);
          write_tag_array  = last_s;
        end else begin
          write_data_array = 1'b0;
        end
      end
      default: begin
        fsm_busy = 1'b0;
      end
    endcase
  end

  // State, latched miss context, request counters and sticky error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      base_r      <= {ADDR_W{1'b0}};
      start_r     <= {LW{1'b0}};
      miss_word_r <= {LW{1'b0}};
      issue_cnt_r <= ZERO_C;
      recv_cnt_r  <= ZERO_C;
      error_r     <= 1'b0;
    end else begin
      error_r <= error_r | bad_data_s;
      case (state_r)
        IDLE: begin
          if (miss_detected) begin
            state_r     <= FILL;
            base_r      <= base_in_s;
            start_r     <= start_in_s;
            miss_word_r <= miss_word_in_s;
            issue_cnt_r <= ZERO_C;
            recv_cnt_r  <= ZERO_C;
          end
        end
        FILL: begin
          if (issue_s) begin
            issue_cnt_r <= issue_cnt_r + CW'(1);
          end
          if (recv_s) begin
            recv_cnt_r <= recv_cnt_r + CW'(1);
          end
          // A miss arriving on the completing cycle is picked up from IDLE next cycle.
          if (last_s) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_ctrl_param.sv
// Scoreboard bench for cache_fill_ctrl_param: one instance per configuration, a latency
// model for the memory, and a negedge monitor that checks issues and writes in order.
module tb_cache_fill_ctrl_param;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int          act = 0;
  int          max_out = 4;
  int          lat = 2;
  logic        miss_det = 1'b0;
  logic [15:0] miss_addr = 16'h0000;
  logic        grant = 1'b1;
  logic        dv = 1'b0;
  logic        inject_dv = 1'b0;

  logic        md0, md1, gr0, gr1, dv0, dv1;
  logic [15:0] ma0, ma1;
  logic        req0, busy0, wd0, wt0, cw0, err0;
  logic        req1, busy1, wd1, wt1, cw1, err1;
  logic [15:0] addr0, addr1;
  logic [2:0]  wn0, wn1;

  assign md0 = (act == 0) && miss_det;
  assign md1 = (act == 1) && miss_det;
  assign ma0 = (act == 0) ? miss_addr : 16'h0000;
  assign ma1 = (act == 1) ? miss_addr : 16'h0000;
  assign gr0 = (act == 0) ? grant : 1'b1;
  assign gr1 = (act == 1) ? grant : 1'b1;
  assign dv0 = (act == 0) && (dv || inject_dv);
  assign dv1 = (act == 1) && (dv || inject_dv);

  cache_fill_ctrl_param #(.ADDR_W(16), .WORDS_PER_BLOCK(W), .MAX_OUTSTANDING(4), .CRITICAL_FIRST(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .miss_detected(md0), .miss_address(ma0), .mem_grant(gr0),
    .mem_data_valid(dv0), .mem_req(req0), .memory_address(addr0), .fsm_busy(busy0),
    .write_data_array(wd0), .write_tag_array(wt0), .word_num(wn0), .crit_word_valid(cw0),
    .error(err0));

  cache_fill_ctrl_param #(.ADDR_W(16), .WORDS_PER_BLOCK(W), .MAX_OUTSTANDING(2), .CRITICAL_FIRST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .miss_detected(md1), .miss_address(ma1), .mem_grant(gr1),
    .mem_data_valid(dv1), .mem_req(req1), .memory_address(addr1), .fsm_busy(busy1),
    .write_data_array(wd1), .write_tag_array(wt1), .word_num(wn1), .crit_word_valid(cw1),
    .error(err1));

  logic        a_req, a_busy, a_wd, a_wt, a_cw, a_err;
  logic [15:0] a_addr;
  logic [2:0]  a_wn;
  assign a_req  = (act == 1) ? req1  : req0;
  assign a_busy = (act == 1) ? busy1 : busy0;
  assign a_wd   = (act == 1) ? wd1   : wd0;
  assign a_wt   = (act == 1) ? wt1   : wt0;
  assign a_cw   = (act == 1) ? cw1   : cw0;
  assign a_err  = (act == 1) ? err1  : err0;
  assign a_addr = (act == 1) ? addr1 : addr0;
  assign a_wn   = (act == 1) ? wn1   : wn0;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Memory model: in-order returns a fixed number of cycles after each issue.
  int cyc = 0;
  int mq[$];
  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
    end else begin
      if (dv && mq.size() > 0) void'(mq.pop_front());
      if (a_req && grant) mq.push_back(cyc + lat);
    end
    cyc++;
    #1 dv = rst_n && (mq.size() > 0) && (mq[0] <= cyc);
  end

  // Scoreboard monitor.
  logic [15:0] exp_addr[$];
  logic [4:0]  exp_wr[$];
  int out_m = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      out_m = 0;
    end else begin
      if (a_req && grant) begin
        if (exp_addr.size() == 0) check("unexpected_issue", {16'h0, a_addr}, 32'hFFFF_FFFF);
        else check("mem_addr", {16'h0, a_addr}, {16'h0, exp_addr.pop_front()});
      end
      if (a_wd) begin
        if (exp_wr.size() == 0) check("unexpected_write", {27'h0, a_wt, a_cw, a_wn}, 32'hFFFF_FFFF);
        else check("write_tag_crit_word", {27'h0, a_wt, a_cw, a_wn}, {27'h0, exp_wr.pop_front()});
      end else if (a_wt || a_cw) begin
        check("strobe_without_write", {30'h0, a_wt, a_cw}, 32'h0);
      end
      if (out_m >= max_out) check("req_drop_at_max_outstanding", {31'h0, a_req}, 32'h0);
      out_m = out_m + ((a_req && grant) ? 1 : 0) - (a_wd ? 1 : 0);
    end
  end

  task automatic start_miss(input logic [15:0] addr);
    logic [2:0]  mw, st, idx;
    logic [15:0] base;
    mw   = addr[3:1];
    st   = (act == 1) ? mw : 3'd0;
    base = addr & 16'hFFF0;
    for (int i = 0; i < W; i++) begin
      idx = st + 3'(i);
      exp_addr.push_back(base | {12'h000, idx, 1'b0});
      exp_wr.push_back({(i == W - 1), (idx == mw), idx});
    end
    @(posedge clk);
    #2 miss_addr = addr;
    miss_det = 1'b1;
    #1 check("idle_busy_on_miss", {31'h0, a_busy}, 32'h1);
    check("idle_addr_passthrough", {16'h0, a_addr}, {16'h0, addr});
    @(posedge clk);
    #2 miss_det = 1'b0;
    miss_addr = 16'h0000;
  endtask

  task automatic wait_done();
    int k = 0;
    while (exp_wr.size() != 0 && k < 300) begin
      @(posedge clk);
      #2 k++;
    end
    check("fill_complete", exp_wr.size(), 0);
    check("all_addresses_issued", exp_addr.size(), 0);
    check("busy_low_after_fill", {31'h0, a_busy}, 32'h0);
  endtask

  logic [15:0] saved_addr;

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #2 check("reset_outputs_dut0", {req0, addr0, busy0, wd0, wt0, wn0, cw0, err0}, 32'h0);
    check("reset_outputs_dut1", {req1, addr1, busy1, wd1, wt1, wn1, cw1, err1}, 32'h0);
    rst_n = 1'b1;

    // Linear fill, latency 2.
    act = 0; max_out = 4; lat = 2;
    start_miss(16'h1234);
    wait_done();

    // Critical-word-first fill.
    act = 1; max_out = 2; lat = 2;
    start_miss(16'h123A);
    wait_done();

    // Outstanding cap of 2 with latency 4.
    lat = 4;
    start_miss(16'h2002);
    wait_done();

    // Grant withdrawn for 5 cycles mid-fill.
    act = 0; max_out = 4; lat = 2;
    start_miss(16'h3456);
    repeat (2) @(posedge clk);
    #2 grant = 1'b0;
    @(negedge clk);
    saved_addr = a_addr;
    check("req_held_no_grant", {31'h0, a_req}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("req_held_no_grant", {31'h0, a_req}, 32'h1);
      check("addr_frozen_no_grant", {16'h0, a_addr}, {16'h0, saved_addr});
    end
    @(posedge clk);
    #2 grant = 1'b1;
    wait_done();

    // Stray data-valid in IDLE sets the sticky error.
    @(posedge clk);
    #2 inject_dv = 1'b1;
    @(posedge clk);
    #2 inject_dv = 1'b0;
    check("error_set_idle_dv", {31'h0, err0}, 32'h1);
    repeat (3) @(posedge clk);
    #2 check("error_sticky", {31'h0, err0}, 32'h1);

    // Reset in the middle of a fill, then a clean fill.
    start_miss(16'h0100);
    begin
      int k = 0;
      while (exp_wr.size() > W - 3 && k < 300) begin
        @(posedge clk);
        #2 k++;
      end
    end
    check("three_words_before_reset", exp_wr.size(), W - 3);
    rst_n = 1'b0;
    @(posedge clk);
    #2 check("midfill_reset_outputs", {req0, addr0, busy0, wd0, wt0, wn0, cw0, err0}, 32'h0);
    exp_addr.delete();
    exp_wr.delete();
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2 check("idle_after_abandon", {req0, busy0, wd0, wt0, err0}, 32'h0);
    start_miss(16'h0040);
    wait_done();
    check("no_error_after_clean_fill", {31'h0, err0}, 32'h0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
